pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage 16-bit RISC core. It drives the enable/clear pairs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC enable. It resolves three conditions: load-use stalls, taken-branch flushes and memory-busy freezes. It also unrolls LM/SM instructions into one micro-op per selected register.

## Interface
Parameters:
- none (opcodes and state encodings come from the shared package)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_opcode  in  4  opcode of instruction in ID (IF_ID output)
- id_src_a, id_src_b  in  3 each  source register fields of ID instruction
- id_uses_a, id_uses_b  in  1 each  ID instruction reads src_a / src_b
- id_lmsm_mask  in  8  register mask field of LM/SM in ID (bit i = R_i)
- ex_is_load  in  1  instruction in EX is LW or an LM micro-op
- ex_dest  in  3  destination register of EX instruction
- ex_br_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_en  out  1  PC update enable
- if_id_en, if_id_clr  out  1 each
- id_ex_en, id_ex_clr  out  1 each
- ex_mem_en, ex_mem_clr  out  1 each
- mem_wb_en, mem_wb_clr  out  1 each
- lmsm_active  out  1  ID_EX is being loaded with an LM/SM micro-op
- lmsm_reg  out  3  register index of current micro-op
- lmsm_offset  out  4  byte offset of current micro-op address (0,2,4…14)

## Operation
- FSM states: RUN, MULTI. Reset → RUN, mask register = 0, offset counter = 0.
- Decision priority, evaluated every cycle: rst > mem_busy > ex_br_taken > load-use > LM/SM entry/step > normal.
- Normal (RUN, no event):
  - all *_en = 1, all *_clr = 0, pc_en = 1
  - lmsm_active = 0, lmsm_reg = 0, lmsm_offset = 0
- mem_busy = 1:
  - all *_en = 0, all *_clr = 0, pc_en = 0
  - FSM, mask and offset hold
  - mem_busy masks every other event in that cycle.
- ex_br_taken = 1:
  - if_id_clr = 1 and id_ex_clr = 1; the other EN stay at 1
  - FSM forced to RUN, mask cleared, offset cleared
  - an LM/SM in ID or in progress is squashed.
- Load-use (RUN only): ex_is_load and ex_dest matches id_src_a (with id_uses_a) or id_src_b (with id_uses_b).
  - pc_en = 0, if_id_en = 0, id_ex_clr = 1 (bubble); remaining stages advance
  - lasts exactly while the condition holds, normally 1 cycle.
- LM/SM entry (RUN, id_opcode ∈ {LM, SM}, mask ≠ 0, no higher-priority event):
  - latch mask, go to MULTI next cycle
  - this cycle: pc_en = 0, if_id_en = 0, id_ex_en = 0.
- Mask = 0 LM/SM: passes through as a normal instruction; no MULTI entry.
- MULTI, each non-frozen cycle:
  - lmsm_active = 1, lmsm_reg = index of lowest set mask bit, lmsm_offset = counter
  - id_ex_en = 1, pc_en = 0, if_id_en = 0
  - clear that mask bit, counter += 2 (4-bit, no wrap since ≤8 ops)
  - on issuing the last set bit: next state RUN, counter → 0, and pc_en/if_id_en = 1 that same cycle so the following instruction advances.
- Load-use checks are suppressed in MULTI.

## Timing
- All outputs are combinational from registered state plus current inputs, with zero-cycle response.
- State, mask and counter update on rising clk.
- Reset values of outputs (rst = 1 forces): all *_clr = 1, all *_en = 0, pc_en = 0, lmsm_active = 0, lmsm_reg = 0, lmsm_offset = 0.
- Reset mid-MULTI abandons the sequence; next cycle is RUN.
- LM/SM with k set bits: 1 entry cycle + k micro-op cycles (excluding mem_busy cycles). Fetch resumes on cycle k+1 after entry.
- Simultaneous ex_br_taken and load-use: flush wins, with no stall.

## Structure
- Shared package pipe_ctrl_pkg: opcodes OP_LW = 4'b0100, OP_LM = 4'b0110, OP_SM = 4'b0111; state encoding ST_RUN = 1'b0, ST_MULTI = 1'b1.
- One sub-module: lmsm_prio_enc (8-bit lowest-set-bit encoder producing 3-bit index and a last-bit flag).

## Test plan
- Reset held 2 cycles → all CLR = 1, EN = 0; after release, RUN with all EN = 1 and pc_en = 1.
- ex_is_load = 1, ex_dest = 3, id_src_a = 3, id_uses_a = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_clr = 1, then normal.
- LM with mask 8'b1010_0100 → entry cycle, then lmsm_reg = 2, 5, 7 with offsets 0, 2, 4; RUN and pc_en = 1 on the third micro-op.
- SM mask 8'hFF with mem_busy on the 4th micro-op for 2 cycles → outputs frozen with lmsm_reg = 3 held; 8 micro-ops total, offset reaches 14.
- ex_br_taken during MULTI after 2 micro-ops → if_id_clr = id_ex_clr = 1, RUN next cycle, lmsm_active = 0.
- ex_br_taken concurrent with a load-use match → flush only; pc_en = 1, if_id_en = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode and state definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    // True for the multi-register load/store opcodes that get unrolled.
    function automatic logic is_lmsm_op(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder for the LM/SM register mask.
// last is high when exactly one bit remains, i.e. this is the final micro-op.
module lmsm_prio_enc (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       last
);

    // Scan from high to low so the lowest set bit is the final assignment.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        last = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// memory-busy freezes and LM/SM unrolling into per-register micro-ops.
// Event priority each cycle: rst > mem_busy > ex_br_taken > load-use
// > LM/SM entry/step > normal flow.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_opcode,
    input  logic [2:0] id_src_a,
    input  logic [2:0] id_src_b,
    input  logic       id_uses_a,
    input  logic       id_uses_b,
    input  logic [7:0] id_lmsm_mask,
    input  logic       ex_is_load,
    input  logic [2:0] ex_dest,
    input  logic       ex_br_taken,
    input  logic       mem_busy,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_clr,
    output logic       id_ex_en,
    output logic       id_ex_clr,
    output logic       ex_mem_en,
    output logic       ex_mem_clr,
    output logic       mem_wb_en,
    output logic       mem_wb_clr,
    output logic       lmsm_active,
    output logic [2:0] lmsm_reg,
    output logic [3:0] lmsm_offset
);

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] offset_q, offset_d;

    logic [2:0] enc_idx;
    logic       enc_last;
    logic       load_use;

    lmsm_prio_enc u_prio_enc (
        .mask (mask_q),
        .idx  (enc_idx),
        .last (enc_last)
    );

    assign load_use = ex_is_load &&
                      ((id_uses_a && (ex_dest == id_src_a)) ||
                       (id_uses_b && (ex_dest == id_src_b)));

    // State, remaining mask and address offset registers.
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        mask_q   <= mask_d;
        offset_q <= offset_d;
    end

    // Next-state and pipeline-register control, highest-priority event first.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        offset_d    = offset_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_clr   = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_clr   = 1'b0;
        ex_mem_en   = 1'b1;
        ex_mem_clr  = 1'b0;
        mem_wb_en   = 1'b1;
        mem_wb_clr  = 1'b0;
        lmsm_active = 1'b0;
        lmsm_reg    = 3'd0;
        lmsm_offset = 4'd0;

        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            if_id_clr  = 1'b1;
            id_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
            mem_wb_clr = 1'b1;
            state_d    = ST_RUN;
            mask_d     = 8'd0;
            offset_d   = 4'd0;
        end else if (mem_busy) begin
            // Freeze everything; an in-flight micro-op keeps presenting itself.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            if (state_q == ST_MULTI) begin
                lmsm_active = 1'b1;
                lmsm_reg    = enc_idx;
                lmsm_offset = offset_q;
            end
        end else if (ex_br_taken) begin
            // Flush the two younger stages and abandon any LM/SM sequence.
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            state_d   = ST_RUN;
            mask_d    = 8'd0;
            offset_d  = 4'd0;
        end else if (state_q == ST_RUN) begin
            if (load_use) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_clr = 1'b1;
            end else if (is_lmsm_op(id_opcode) && (id_lmsm_mask != 8'd0)) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                state_d  = ST_MULTI;
                mask_d   = id_lmsm_mask;
                offset_d = 4'd0;
            end
        end else begin
            // One micro-op per cycle; fetch resumes alongside the last one.
            lmsm_active = 1'b1;
            lmsm_reg    = enc_idx;
            lmsm_offset = offset_q;
            mask_d      = mask_q & ~(8'd1 << enc_idx);
            offset_d    = offset_q + 4'd2;
            if (enc_last) begin
                state_d  = ST_RUN;
                offset_d = 4'd0;
            end else begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
            end
        end
    end

endmodule
